// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Operation codes driven by the decoder and the controller state encoding.
package mdu_iter_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIX  = 2'd2
   } mdu_state_t;

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide loop on unsigned magnitudes.
// Multiply: {carry,upper} += operand when the multiplier LSB is set, then shift right.
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic                 div_mode,
   input  logic [2*WIDTH-1:0]   partial,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   next_partial
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] addend;

   // Divide: shift remainder:quotient left, keep the trial subtraction when it does not borrow.
   always_comb begin
      addend = partial[0] ? operand : '0;
      sum    = {1'b0, partial[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      trial  = partial[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
      if (!div_mode)
         next_partial = {sum, partial[WIDTH-1:1]};
      else if (!trial[WIDTH])
         next_partial = {trial[WIDTH-1:0], partial[WIDTH-2:0], 1'b1};
      else
         next_partial = {partial[2*WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Operands are reduced to magnitudes at acceptance; signs are restored in the FIX state.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

   mdu_state_t         state;
   logic [2*WIDTH-1:0] partial;
   logic [2*WIDTH-1:0] next_partial;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] fast_prod;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic [CW-1:0]      counter;
   logic               div_mode;
   logic               neg_prod;
   logic               neg_rem;
   logic               op_signed;

   assign op_signed = is_signed_op(op);
   assign a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
   assign b_mag     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
   assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};

   // neg_prod doubles as the quotient sign when dividing.
   assign product = neg_prod ? -partial : partial;
   assign q_fix   = neg_prod ? -partial[WIDTH-1:0] : partial[WIDTH-1:0];
   assign r_fix   = neg_rem ? -partial[2*WIDTH-1:WIDTH] : partial[2*WIDTH-1:WIDTH];

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .div_mode     (div_mode),
      .partial      (partial),
      .operand      (operand),
      .next_partial (next_partial)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= MDU_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         counter  <= '0;
         partial  <= '0;
         operand  <= '0;
         div_mode <= 1'b0;
         neg_prod <= 1'b0;
         neg_rem  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MDU_IDLE: begin
               if (start && !flush) begin
                  case (op)
                     MDU_MTHI: hi <= src_a;
                     MDU_MTLO: lo <= src_a;
                     MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        busy     <= 1'b1;
                        div_mode <= op[1];
                        neg_prod <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_rem  <= op_signed && src_a[WIDTH-1];
                        operand  <= op[1] ? b_mag : a_mag;
                        partial  <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        counter  <= CNT_INIT;
                        state    <= MDU_CALC;
                        // Divide by zero skips the loop with a fixed, unsigned result.
                        if (op[1] && (src_b == '0)) begin
                           partial  <= {src_a, {WIDTH{1'b1}}};
                           neg_prod <= 1'b0;
                           neg_rem  <= 1'b0;
                           state    <= MDU_FIX;
                        end else if (FAST_MUL && !op[1]) begin
                           partial <= fast_prod;
                           state   <= MDU_FIX;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            MDU_CALC: begin
               if (flush) begin
                  state <= MDU_IDLE;
                  busy  <= 1'b0;
               end else begin
                  partial <= next_partial;
                  counter <= counter - CW'(1);
                  if (counter == CW'(1))
                     state <= MDU_FIX;
               end
            end
            MDU_FIX: begin
               state <= MDU_IDLE;
               busy  <= 1'b0;
               if (!flush) begin
                  done <= 1'b1;
                  if (div_mode) begin
                     hi <= r_fix;
                     lo <= q_fix;
                  end else begin
                     {hi, lo} <= product;
                  end
               end
            end
            default: begin
               state <= MDU_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: an iterative and a FAST_MUL instance checked
// every cycle against a latency/arithmetic model, plus directed literal cases.
module tb_mdu_iter;
   import mdu_iter_pkg::*;

   logic             clk = 1'b0;
   logic             resetn;
   logic [1:0]       start;
   logic [1:0]       flush;
   logic [1:0][2:0]  op;
   logic [1:0][31:0] src_a;
   logic [1:0][31:0] src_b;
   logic [1:0]       busy;
   logic [1:0]       done;
   logic [1:0][31:0] hi;
   logic [1:0][31:0] lo;

   int tests = 0;
   int fails = 0;
   bit checking = 1'b0;

   // Model state per instance: pending result and edges left until it lands.
   bit          pend[2];
   int          left[2];
   logic [63:0] pres[2];
   logic [31:0] m_hi[2];
   logic [31:0] m_lo[2];
   bit          m_done[2];

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(32), .FAST_MUL(1'b0)) dut_iter (
      .clk(clk), .resetn(resetn), .start(start[0]), .op(op[0]),
      .src_a(src_a[0]), .src_b(src_b[0]), .flush(flush[0]),
      .busy(busy[0]), .done(done[0]), .hi(hi[0]), .lo(lo[0])
   );

   mdu_iter #(.WIDTH(32), .FAST_MUL(1'b1)) dut_fast (
      .clk(clk), .resetn(resetn), .start(start[1]), .op(op[1]),
      .src_a(src_a[1]), .src_b(src_b[1]), .flush(flush[1]),
      .busy(busy[1]), .done(done[1]), .hi(hi[1]), .lo(lo[1])
   );

   // Reference arithmetic: returns {hi, lo}.
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         MDU_MULT:  return 64'(sa * sb);
         MDU_MULTU: return {32'd0, a} * {32'd0, b};
         MDU_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            qv = 64'(q);
            rv = 64'(r);
            return {rv[31:0], qv[31:0]};
         end
         MDU_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic checkOutput(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s inst%0d at %0t: got %h expected %h", name, inst, $time, act, exp);
      end
   endtask

   // Behavioural model, advanced on each clock edge or asynchronous reset.
   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
               pend[i] = 0; left[i] = 0; m_hi[i] = '0; m_lo[i] = '0; m_done[i] = 0;
            end else begin
               m_done[i] = 0;
               if (pend[i]) begin
                  if (flush[i]) pend[i] = 0;
                  else begin
                     left[i]--;
                     if (left[i] == 0) begin
                        {m_hi[i], m_lo[i]} = pres[i];
                        m_done[i] = 1;
                        pend[i] = 0;
                     end
                  end
               end else if (start[i] && !flush[i]) begin
                  if (op[i] == MDU_MTHI) m_hi[i] = src_a[i];
                  else if (op[i] == MDU_MTLO) m_lo[i] = src_a[i];
                  else if (op[i] <= MDU_DIVU) begin
                     pend[i] = 1;
                     pres[i] = ref_result(op[i], src_a[i], src_b[i]);
                     left[i] = ((op[i][1] && src_b[i] == 32'd0) || (i == 1 && !op[i][1])) ? 1 : 33;
                  end
               end
            end
         end
      end
   end

   // Per-cycle comparison on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (checking) begin
            for (int i = 0; i < 2; i++) begin
               checkOutput("busy", i, 64'(busy[i]), 64'(pend[i]));
               checkOutput("done", i, 64'(done[i]), 64'(m_done[i]));
               checkOutput("hi", i, 64'(hi[i]), 64'(m_hi[i]));
               checkOutput("lo", i, 64'(lo[i]), 64'(m_lo[i]));
            end
         end
      end
   end

   // Drive a one-cycle request; returns in the first cycle after acceptance.
   task automatic applyStimulus(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start[i] = 1'b1; op[i] = o; src_a[i] = a; src_b[i] = b;
      @(posedge clk); #1;
      start[i] = 1'b0; src_a[i] = $urandom; src_b[i] = $urandom;
   endtask

   task automatic waitDone(input int i, input int exp_cycle, input string name);
      int n = 1;
      while (!done[i] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({name, "_cycle"}, i, 64'(n), 64'(exp_cycle));
   endtask

   task automatic runOp(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input logic [31:0] eh, input logic [31:0] el, input string name);
      applyStimulus(i, o, a, b);
      waitDone(i, cyc, name);
      checkOutput({name, "_hi"}, i, 64'(hi[i]), 64'(eh));
      checkOutput({name, "_lo"}, i, 64'(lo[i]), 64'(el));
   endtask

   initial begin
      start = '0; flush = '0; op = '0; src_a = '0; src_b = '0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 0, 64'(busy[0]), 64'd0);
      checkOutput("reset_done", 0, 64'(done[0]), 64'd0);
      checkOutput("reset_hi", 0, 64'(hi[0]), 64'd0);
      checkOutput("reset_lo", 0, 64'(lo[0]), 64'd0);
      resetn = 1'b1;
      checking = 1'b1;

      runOp(0, MDU_MULT, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
      runOp(0, MDU_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, "divu");
      runOp(0, MDU_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
      runOp(0, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, "div_ovf");
      runOp(0, MDU_DIVU, 32'h1234, 32'd0, 2, 32'h1234, 32'hFFFF_FFFF, "div_zero");

      // Flush an in-flight multiply in cycle 10.
      applyStimulus(0, MDU_MTHI, 32'hA5A5_A5A5, 32'd0);
      applyStimulus(0, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) begin @(posedge clk); #1; end
      flush[0] = 1'b1;
      @(posedge clk); #1;
      flush[0] = 1'b0;
      checkOutput("flush_busy", 0, 64'(busy[0]), 64'd0);
      checkOutput("flush_hi", 0, 64'(hi[0]), 64'hA5A5_A5A5);
      repeat (30) begin
         @(posedge clk); #1;
         checkOutput("flush_nodone", 0, 64'(done[0]), 64'd0);
      end

      runOp(0, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");

      // Reset in the middle of a divide.
      applyStimulus(0, MDU_DIV, 32'd1000, 32'd3);
      repeat (4) begin @(posedge clk); #1; end
      resetn = 1'b0;
      #1;
      checkOutput("rst_busy", 0, 64'(busy[0]), 64'd0);
      checkOutput("rst_hi", 0, 64'(hi[0]), 64'd0);
      checkOutput("rst_lo", 0, 64'(lo[0]), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;

      runOp(1, MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 2, 32'd1, 32'd0, "fast_multu");
      runOp(1, MDU_MULT, 32'hFFFF_FFFD, 32'd5, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "fast_mult");

      // Randomized traffic on both instances, checked by the model every cycle.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            start[i] = ($urandom % 3) == 0;
            op[i]    = 3'($urandom % 8);
            src_a[i] = pick();
            src_b[i] = pick();
            flush[i] = ($urandom % 80) == 0;
         end
      end
      @(posedge clk); #1;
      start = '0; flush = '0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      checking = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
